seq_detector_kmp: RTL and testbench

Runtime-programmable sequence detector: successor to the fixed-pattern, single-bit `SequenceDetector`. A pattern of up to `MAX_LEN` symbols, each `SYM_W` bits wide, is loaded through a config port. An internal FSM then builds the KMP failure table in hardware. The matcher scans a valid-qualified symbol stream at one symbol per cycle, with selectable overlapping or non-overlapping detection and a saturating match counter. It sits between the stimulus/data source and whatever consumes `detected`.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_det_fail_builder.sv | 68 ++++++
 rtl/seq_detector_kmp.sv | 171 +++++++++++++++++
 tb/tb_seq_detector_kmp.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and width helpers for the runtime-programmable KMP sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        RUN   = 2'd2
    } state_e;

    function automatic int calc_idx_w(input int max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_fail_builder.sv
// KMP prefix-function engine: one step per cycle, writes fail[1..len-1] into the top's table.
module seq_det_fail_builder
    import seq_det_pkg::*;
#(
    parameter int SYM_W   = 1,
    parameter int MAX_LEN = 8,
    parameter int IDX_W   = calc_idx_w(MAX_LEN),
    parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic [IDX_W-1:0] pat_i_idx,
    output logic [IDX_W-1:0] pat_k_idx,
    output logic [IDX_W-1:0] fail_rd_idx,
    input  logic [SYM_W-1:0] pat_i_sym,
    input  logic [SYM_W-1:0] pat_k_sym,
    input  logic [IDX_W-1:0] fail_rd_val,
    output logic             fail_we,
    output logic [IDX_W-1:0] fail_waddr,
    output logic [IDX_W-1:0] fail_wdata,
    output logic             done
);

    logic [LEN_W-1:0] i_p0;
    logic [IDX_W-1:0] k_p0;
    logic             active_p0;
    logic             step;
    logic             sym_eq;

    assign pat_i_idx   = i_p0[IDX_W-1:0];
    assign pat_k_idx   = k_p0;
    assign fail_rd_idx = k_p0 - IDX_W'(1);
    assign sym_eq      = (pat_i_sym == pat_k_sym);
    assign step        = active_p0 && (i_p0 != len);
    assign done        = active_p0 && (i_p0 == len);

    // A fail entry is produced either by extending the border or by exhausting it at k=0
    assign fail_we    = step && (sym_eq || (k_p0 == '0));
    assign fail_waddr = i_p0[IDX_W-1:0];
    assign fail_wdata = sym_eq ? (k_p0 + IDX_W'(1)) : '0;

    // ---- stage p0: build state registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_p0      <= LEN_W'(1);
            k_p0      <= '0;
            active_p0 <= 1'b0;
        end else if (start) begin
            i_p0      <= LEN_W'(1);
            k_p0      <= '0;
            active_p0 <= 1'b1;
        end else if (active_p0) begin
            if (i_p0 == len) begin
                active_p0 <= 1'b0;
            end else if (sym_eq) begin
                k_p0 <= k_p0 + IDX_W'(1);
                i_p0 <= i_p0 + LEN_W'(1);
            end else if (k_p0 != '0) begin
                k_p0 <= fail_rd_val;
            end else begin
                i_p0 <= i_p0 + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detector_kmp.sv
// Programmable sequence detector: pattern RAM, IDLE/BUILD/RUN control, KMP matcher and
// saturating match counter.
module seq_detector_kmp
    import seq_det_pkg::*;
#(
    parameter int SYM_W     = 1,
    parameter int MAX_LEN   = 8,
    parameter int CNT_W     = 16,
    localparam int IDX_W    = calc_idx_w(MAX_LEN),
    localparam int LEN_W    = calc_len_w(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [SYM_W-1:0] cfg_sym,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cfg_start,
    input  logic             cnt_clr,
    input  logic             data_valid,
    input  logic [SYM_W-1:0] data_in,
    output logic             busy,
    output logic             ready,
    output logic             detected,
    output logic [CNT_W-1:0] match_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] v);
        return (v > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : v;
    endfunction

    state_e           state_q, state_d;
    logic [SYM_W-1:0] pat      [MAX_LEN];
    logic [IDX_W-1:0] fail_tbl [MAX_LEN];
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;
    logic [IDX_W-1:0] q_p0;
    logic             det_p1;
    logic [CNT_W-1:0] count_p1;

    logic             start_req, go_build, go_idle, run_stay;
    logic [IDX_W-1:0] pat_i_idx, pat_k_idx, fail_rd_idx;
    logic             fail_we, bld_done;
    logic [IDX_W-1:0] fail_waddr, fail_wdata;

    logic [IDX_W-1:0] q_fb, q_next;
    logic [LEN_W-1:0] q_inc;
    logic             sym_hit, full_hit;

    // cfg_start is ignored only while the table is being built
    assign start_req = cfg_start && (state_q != BUILD);
    assign go_build  = start_req && (cfg_len != '0);
    assign go_idle   = start_req && (cfg_len == '0);
    assign run_stay  = (state_q == RUN) && (state_d == RUN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go_build) state_d = BUILD;
            BUILD:   if (bld_done) state_d = RUN;
            RUN: begin
                if (go_build)     state_d = BUILD;
                else if (go_idle) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            len_q     <= LEN_W'(1);
            overlap_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (go_build) begin
                len_q     <= clamp_len(cfg_len);
                overlap_q <= cfg_overlap;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < MAX_LEN; n++) begin
                pat[n]      <= '0;
                fail_tbl[n] <= '0;
            end
        end else begin
            if (state_q == IDLE && cfg_we && (int'(cfg_idx) < MAX_LEN))
                pat[cfg_idx] <= cfg_sym;
            if (fail_we)
                fail_tbl[fail_waddr] <= fail_wdata;
        end
    end

    seq_det_fail_builder #(
        .SYM_W   (SYM_W),
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W),
        .LEN_W   (LEN_W)
    ) u_builder (
        .clk         (clk),
        .reset       (reset),
        .start       (go_build),
        .len         (len_q),
        .pat_i_idx   (pat_i_idx),
        .pat_k_idx   (pat_k_idx),
        .fail_rd_idx (fail_rd_idx),
        .pat_i_sym   (pat[pat_i_idx]),
        .pat_k_sym   (pat[pat_k_idx]),
        .fail_rd_val (fail_tbl[fail_rd_idx]),
        .fail_we     (fail_we),
        .fail_waddr  (fail_waddr),
        .fail_wdata  (fail_wdata),
        .done        (bld_done)
    );

    // Fallback chain fully unrolled: MAX_LEN hops always reach a consistent q within one cycle
    always_comb begin
        q_fb = q_p0;
        for (int n = 0; n < MAX_LEN; n++) begin
            if (q_fb != '0 && pat[q_fb] != data_in)
                q_fb = fail_tbl[q_fb - IDX_W'(1)];
        end
        sym_hit  = (pat[q_fb] == data_in);
        q_inc    = LEN_W'(q_fb) + LEN_W'(1);
        full_hit = sym_hit && (q_inc == len_q);
        if (full_hit)
            q_next = overlap_q ? fail_tbl[IDX_W'(len_q - LEN_W'(1))] : '0;
        else if (sym_hit)
            q_next = q_inc[IDX_W-1:0];
        else
            q_next = q_fb;
    end

    // ---- stage p0: match state ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_p0 <= '0;
        else if (!run_stay)
            q_p0 <= '0;
        else if (data_valid)
            q_p0 <= q_next;
    end

    // ---- stage p1: detection pulse and counter ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_p1   <= 1'b0;
            count_p1 <= '0;
        end else begin
            det_p1 <= run_stay && data_valid && full_hit;
            if (cnt_clr)
                count_p1 <= '0;
            else if (run_stay && data_valid && full_hit)
                count_p1 <= sat_inc(count_p1);
        end
    end

    assign busy        = (state_q == BUILD);
    assign ready       = (state_q == RUN);
    assign detected    = det_p1;
    assign match_count = count_p1;

endmodule

// File: tb/tb_seq_detector_kmp.sv
// Scoreboard bench for seq_detector_kmp: sliding-window reference model, queued expectations,
// independent monitor.
module tb_seq_detector_kmp;

    localparam int SYM_W   = 4;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 3;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [SYM_W-1:0] sym_t;
    typedef struct packed {
        logic             det;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic [SYM_W-1:0] cfg_sym = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             cfg_start = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             data_valid = 1'b0;
    logic [SYM_W-1:0] data_in = '0;
    logic             busy, ready, detected;
    logic [CNT_W-1:0] match_count;

    seq_detector_kmp #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_start(cfg_start), .cnt_clr(cnt_clr),
        .data_valid(data_valid), .data_in(data_in), .busy(busy), .ready(ready),
        .detected(detected), .match_count(match_count)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   det_seen = 0;
    exp_t exp_q[$];
    logic evt = 1'b0;

    sym_t m_pat[$];
    sym_t m_hist[$];
    int   m_len = 1;
    bit   m_ovl = 1'b0;
    int   m_since = 0;
    int   m_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // A match is any window of the last m_len accepted symbols equal to the pattern;
    // without overlap the window must also lie entirely after the previous match.
    function automatic bit model_accept(input sym_t s);
        bit hit;
        hit = 1'b1;
        m_hist.push_back(s);
        if (m_hist.size() > m_len) void'(m_hist.pop_front());
        m_since++;
        if (m_hist.size() < m_len) return 1'b0;
        for (int n = 0; n < m_len; n++)
            if (m_hist[n] != m_pat[n]) hit = 1'b0;
        if (!m_ovl && m_since < m_len) hit = 1'b0;
        if (hit) m_since = 0;
        return hit;
    endfunction

    // Longest proper border of pat[0..i], by brute force.
    function automatic int border(input sym_t p[$], input int i);
        for (int b = i; b > 0; b--) begin
            bit ok;
            ok = 1'b1;
            for (int n = 0; n < b; n++)
                if (p[n] != p[i + 1 - b + n]) ok = 1'b0;
            if (ok) return b;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        logic e;
        exp_t x;
        e = evt;
        #1;
        if (e) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 0, 1);
            end else begin
                x = exp_q.pop_front();
                check("detected", detected, x.det);
                check("match_count", match_count, x.cnt);
            end
        end else begin
            check("detected_quiet", detected, 0);
        end
        if (detected) det_seen++;
    end

    // Called and returns at a falling edge; acc says whether the DUT should consume the symbol.
    task automatic drive(input sym_t s, input bit v, input bit clr, input bit acc);
        bit   hit;
        exp_t x;
        hit = 1'b0;
        data_in = s; data_valid = v; cnt_clr = clr;
        if (v && acc) hit = model_accept(s);
        if (clr) m_cnt = 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt++;
        evt = (v && acc) || clr;
        if (evt) begin
            x.det = hit;
            x.cnt = CNT_W'(m_cnt);
            exp_q.push_back(x);
        end
        @(negedge clk);
        data_valid = 1'b0; cnt_clr = 1'b0; evt = 1'b0;
    endtask

    task automatic stream(input sym_t s[$], input bit gaps);
        foreach (s[n]) begin
            if (gaps) while ($urandom_range(2) == 0) drive('0, 1'b0, 1'b0, 1'b1);
            drive(s[n], 1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic go_idle();
        cfg_start = 1'b1; cfg_len = '0;
        @(negedge clk);
        cfg_start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_ready", ready, 0);
    endtask

    task automatic start_build(input int len_cmd, input bit ovl);
        int cyc, l;
        l = (len_cmd > MAX_LEN) ? MAX_LEN : len_cmd;
        cfg_start = 1'b1; cfg_len = LEN_W'(len_cmd); cfg_overlap = ovl;
        @(negedge clk);
        cfg_start = 1'b0;
        check("busy_rise", busy, 1);
        cyc = 0;
        while (busy && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        check("ready_after_build", ready, 1);
        check("busy_fall", busy, 0);
        check("build_cycles_bound", (cyc <= 2 * l - 1) ? 1 : 0, 1);
        if (l == 1) check("build_cycles_len1", cyc, 1);
        m_len = l; m_ovl = ovl; m_hist.delete(); m_since = 0;
    endtask

    task automatic load(input sym_t p[$], input int len_cmd, input bit ovl);
        foreach (p[n]) begin
            cfg_we = 1'b1; cfg_idx = IDX_W'(n); cfg_sym = p[n];
            @(negedge clk);
        end
        cfg_we = 1'b0;
        m_pat = p;
        start_build(len_cmd, ovl);
        for (int n = 0; n < m_len; n++)
            check($sformatf("fail_tbl[%0d]", n), dut.fail_tbl[n], border(m_pat, n));
    endtask

    task automatic expect_run(input string name, input int det0, input int dets, input int cnt);
        check({name, "_detections"}, det_seen - det0, dets);
        check({name, "_count"}, match_count, cnt);
    endtask

    task automatic clear_count();
        drive('0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int   d0;
        sym_t p[$];
        sym_t s[$];

        repeat (2) @(negedge clk);
        check("rst_detected", detected, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_count", match_count, 0);
        reset = 1'b1;
        @(negedge clk);

        // 1011 over 1011011, overlap on then off
        p = '{1, 0, 1, 1};
        s = '{1, 0, 1, 1, 0, 1, 1};
        load(p, 4, 1'b1);
        d0 = det_seen; stream(s, 1'b0); expect_run("ovl_1011", d0, 2, 2);
        clear_count();
        go_idle(); load(p, 4, 1'b0);
        d0 = det_seen; stream(s, 1'b0); expect_run("novl_1011", d0, 1, 1);
        clear_count();

        // 1010 over 1010101 with random valid gaps
        p = '{1, 0, 1, 0};
        s = '{1, 0, 1, 0, 1, 0, 1};
        go_idle(); load(p, 4, 1'b1);
        d0 = det_seen; stream(s, 1'b1); expect_run("ovl_1010_gaps", d0, 2, 2);
        clear_count();
        go_idle(); load(p, 4, 1'b0);
        d0 = det_seen; stream(s, 1'b1); expect_run("novl_1010_gaps", d0, 1, 1);

        // Restart from RUN must discard the partial match
        stream('{1, 0}, 1'b0);
        start_build(4, 1'b1);
        p = '{1, 0, 1, 1};
        go_idle(); load(p, 4, 1'b1);
        clear_count();
        stream('{1, 0}, 1'b0);
        start_build(4, 1'b1);
        d0 = det_seen; stream('{1, 1, 0, 1, 1}, 1'b0); expect_run("restart", d0, 1, 1);
        clear_count();

        // Wide symbols: A,A,B
        p = '{4'hA, 4'hA, 4'hB};
        go_idle(); load(p, 3, 1'b0);
        check("fail_AAB_1", dut.fail_tbl[1], 1);
        check("fail_AAB_2", dut.fail_tbl[2], 0);
        d0 = det_seen; stream('{4'hA, 4'hA, 4'hA, 4'hB}, 1'b0); expect_run("AAB", d0, 1, 1);
        clear_count();

        // Zero-length start from IDLE is ignored
        go_idle(); go_idle();
        for (int n = 0; n < 3; n++) begin
            drive('0, 1'b0, 1'b0, 1'b1);
            check("len0_busy", busy, 0);
        end

        // Saturation, back-to-back pulses, clear beating a same-cycle match
        p = '{1};
        load(p, 1, 1'b1);
        d0 = det_seen; stream('{1, 1, 1, 1, 1, 1}, 1'b0); expect_run("sat", d0, 6, CNT_MAX);
        drive(1, 1'b1, 1'b1, 1'b1);
        check("clr_vs_match", match_count, 0);

        // Oversized cfg_len clamps to MAX_LEN
        p = '{1, 1, 0, 1, 1, 0, 1, 1};
        go_idle(); load(p, 15, 1'b1);
        d0 = det_seen; stream('{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1}, 1'b0);
        expect_run("clamp", d0, 2, 2);

        // Random patterns and streams
        for (int t = 0; t < 8; t++) begin
            int l;
            l = $urandom_range(1, MAX_LEN);
            p.delete();
            for (int n = 0; n < l; n++) p.push_back(sym_t'($urandom_range(1)));
            go_idle(); load(p, l, 1'($urandom_range(1)));
            for (int n = 0; n < 60; n++)
                drive(sym_t'($urandom_range(1)), $urandom_range(3) != 0,
                      $urandom_range(15) == 0, 1'b1);
        end

        // Reset asserted mid-build
        p = '{1, 1, 1, 1, 1, 1, 1, 1};
        go_idle();
        foreach (p[n]) begin
            cfg_we = 1'b1; cfg_idx = IDX_W'(n); cfg_sym = p[n];
            @(negedge clk);
        end
        cfg_we = 1'b0;
        cfg_start = 1'b1; cfg_len = 4'd8; cfg_overlap = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("midbuild_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_detected", detected, 0);
        check("abort_count", match_count, 0);
        m_cnt = 0; m_hist.delete(); m_since = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 10; n++) drive(1, 1'b1, 1'b0, 1'b0);
        check("post_abort_ready", ready, 0);
        check("post_abort_count", match_count, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
